// File: rtl/bomb_round_ctrl.sv
// Round sequencer for the bomb game: picks LFSR-driven targets, scores hits, runs the game clock.
// Optional macro BOMB_MISS_PENALTY_EN: wrong presses and bomb timeouts each cost one point.
module bomb_round_ctrl #(
    parameter int P_CLK_PER_SEC = 50_000_000,
    parameter int P_GAME_SEC    = 30,
    parameter int P_BOMB_SEC    = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [2:0] i_State,
    input  logic [7:0] i_Push,
    output logic [7:0] o_Target,
    output logic [4:0] o_Score,
    output logic       o_Sec30Tick,
    output logic [4:0] o_RemainSec
);
    localparam int BOMB_CYC = P_BOMB_SEC * P_CLK_PER_SEC;
    localparam int BW       = $clog2(BOMB_CYC + 1);
    localparam int SW       = $clog2(P_CLK_PER_SEC + 1);
    localparam logic [BW-1:0] BOMB_LAST = BW'(BOMB_CYC - 1);
    localparam logic [SW-1:0] SEC_LAST  = SW'(P_CLK_PER_SEC - 1);
    localparam logic [4:0]    GAME_SEC  = 5'(P_GAME_SEC);

    typedef enum logic [2:0] {IDLE, ARM, WAIT_HIT, GAP, HOLD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [7:0]    target_q, target_d;
    logic [4:0]    score_q, score_d;
    logic          tick_q, tick_d;
    logic [4:0]    remain_q, remain_d;
    logic [2:0]    prev_idx_q, prev_idx_d;
    logic [BW-1:0] bomb_cnt_q, bomb_cnt_d;
    logic [SW-1:0] sec_cnt_q, sec_cnt_d;

    logic       go_idle, go_run, active, hit, loss, timeout, sec_wrap, expire;
    logic [2:0] arm_idx;

    always_comb begin
        go_idle  = (i_State == 3'b000);
        go_run   = (i_State == 3'b001);
        active   = (state_q == ARM) || (state_q == WAIT_HIT) || (state_q == GAP);
        hit      = (state_q == WAIT_HIT) && (i_Push == target_q);
        timeout  = (state_q == WAIT_HIT) && (bomb_cnt_q == BOMB_LAST);
        sec_wrap = active && go_run && (sec_cnt_q == SEC_LAST);
        expire   = sec_wrap && (remain_q == 5'd1);
        // Never light the same LED twice in a row.
        arm_idx  = (lfsr_q[2:0] == prev_idx_q) ? lfsr_q[2:0] + 3'd1 : lfsr_q[2:0];
`ifdef BOMB_MISS_PENALTY_EN
        loss     = (state_q == WAIT_HIT) && !hit && ((i_Push != 8'h00) || timeout);
`else
        loss     = 1'b0;
`endif
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= IDLE;
            lfsr_q     <= 8'hA5;
            target_q   <= '0;
            score_q    <= '0;
            tick_q     <= 1'b0;
            remain_q   <= GAME_SEC;
            prev_idx_q <= '0;
            bomb_cnt_q <= '0;
            sec_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            target_q   <= target_d;
            score_q    <= score_d;
            tick_q     <= tick_d;
            remain_q   <= remain_d;
            prev_idx_q <= prev_idx_d;
            bomb_cnt_q <= bomb_cnt_d;
            sec_cnt_q  <= sec_cnt_d;
        end
    end

    // Game FSM state overrides the round flow; expiry parks the block in HOLD until idle.
    always_comb begin
        state_d = state_q;
        if (go_idle) begin
            state_d = IDLE;
        end else if (!go_run || expire) begin
            state_d = HOLD;
        end else begin
            case (state_q)
                IDLE:     state_d = ARM;
                ARM:      state_d = WAIT_HIT;
                WAIT_HIT: if (hit || timeout) state_d = GAP;
                GAP:      state_d = ARM;
                HOLD:     state_d = HOLD;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        target_d   = target_q;
        score_d    = score_q;
        tick_d     = 1'b0;
        remain_d   = remain_q;
        prev_idx_d = prev_idx_q;
        bomb_cnt_d = bomb_cnt_q;
        sec_cnt_d  = sec_cnt_q;
        if (go_idle) begin
            target_d   = '0;
            score_d    = '0;
            remain_d   = GAME_SEC;
            prev_idx_d = '0;
            bomb_cnt_d = '0;
            sec_cnt_d  = '0;
        end else begin
            case (state_q)
                ARM: begin
                    target_d   = 8'd1 << arm_idx;
                    prev_idx_d = arm_idx;
                    bomb_cnt_d = '0;
                end
                WAIT_HIT: begin
                    bomb_cnt_d = bomb_cnt_q + 1'b1;
                    if (hit) begin
                        target_d = '0;
                        if (score_q != 5'd31) score_d = score_q + 5'd1;
                    end else begin
                        if (timeout) target_d = '0;
                        if (loss && (score_q != 5'd0)) score_d = score_q - 5'd1;
                    end
                end
                GAP:     target_d = '0;
                default: ;
            endcase
            if (active && go_run) begin
                sec_cnt_d = sec_wrap ? '0 : sec_cnt_q + 1'b1;
                if (sec_wrap) remain_d = remain_q - 5'd1;
                tick_d = expire;
            end
            if (state_d == HOLD) target_d = '0;
        end
    end

    assign o_Target    = target_q;
    assign o_Score     = score_q;
    assign o_Sec30Tick = tick_q;
    assign o_RemainSec = remain_q;
endmodule

// File: tb/tb_bomb_round_ctrl.sv
// Self-checking bench for bomb_round_ctrl; expected scores flow through a scoreboard queue.
// Expectations follow BOMB_MISS_PENALTY_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_bomb_round_ctrl;
`ifdef BOMB_MISS_PENALTY_EN
    localparam bit PENALTY = 1'b1;
`else
    localparam bit PENALTY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state_in = 3'b000;
    logic [7:0] push = 8'h00;
    logic [7:0] target;
    logic [4:0] score;
    logic       tick;
    logic [4:0] remain;
    logic [2:0] s_state = 3'b000;
    logic [7:0] s_push = 8'h00;
    logic [7:0] s_target;
    logic [4:0] s_score;
    logic       s_tick;
    logic [4:0] s_remain;

    int n_vec = 0;
    int n_err = 0;
    int model_score = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    bomb_round_ctrl #(.P_CLK_PER_SEC(10), .P_GAME_SEC(3), .P_BOMB_SEC(2)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_State(state_in), .i_Push(push),
        .o_Target(target), .o_Score(score), .o_Sec30Tick(tick), .o_RemainSec(remain)
    );

    // Long game so one game can reach score saturation.
    bomb_round_ctrl #(.P_CLK_PER_SEC(10), .P_GAME_SEC(31), .P_BOMB_SEC(2)) dut_sat (
        .i_Clk(clk), .i_Rst(rst), .i_State(s_state), .i_Push(s_push),
        .o_Target(s_target), .o_Score(s_score), .o_Sec30Tick(s_tick), .o_RemainSec(s_remain)
    );

    function automatic int after_hit(input int s);
        return (s >= 31) ? 31 : s + 1;
    endfunction

    function automatic int after_loss(input int s);
        return (PENALTY && s > 0) ? s - 1 : s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] val, input int exp_score);
        push = val;
        exp_q.push_back(exp_score);
        step();
        push = 8'h00;
    endtask

    // Leaves the DUT in ARM; the first target is visible after one more step.
    task automatic start_game();
        state_in = 3'b000;
        push = 8'h00;
        step();
        step();
        state_in = 3'b001;
        step();
        model_score = 0;
    endtask

    task automatic test_reset_values();
        rst = 1'b1;
        step();
        step();
        n_vec++; if (target !== 8'h00) begin n_err++; $display("[TB] FAIL rst_target: got %h expected 00", target); end
        n_vec++; if (score !== 5'd0) begin n_err++; $display("[TB] FAIL rst_score: got %0d expected 0", score); end
        n_vec++; if (tick !== 1'b0) begin n_err++; $display("[TB] FAIL rst_tick: got %b expected 0", tick); end
        n_vec++; if (remain !== 5'd3) begin n_err++; $display("[TB] FAIL rst_remain: got %0d expected 3", remain); end
        n_vec++; if (s_remain !== 5'd31) begin n_err++; $display("[TB] FAIL rst_remain_long: got %0d expected 31", s_remain); end
        n_vec++; if (s_tick !== 1'b0) begin n_err++; $display("[TB] FAIL rst_tick_long: got %b expected 0", s_tick); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_hit();
        logic [7:0] prev;
        int got;
        start_game();
        step();
        prev = target;
        n_vec++; if (!$onehot(prev)) begin n_err++; $display("[TB] FAIL hit_first_target: got %h expected one-hot", prev); end
        for (int r = 0; r < 3; r++) begin
            model_score = after_hit(model_score);
            press(target, model_score);
            got = exp_q.pop_front();
            n_vec++; if (score !== 5'(got)) begin n_err++; $display("[TB] FAIL hit_score: got %0d expected %0d", score, got); end
            n_vec++; if (target !== 8'h00) begin n_err++; $display("[TB] FAIL hit_clear: got %h expected 00", target); end
            step();
            n_vec++; if (target !== 8'h00) begin n_err++; $display("[TB] FAIL hit_gap: got %h expected 00", target); end
            step();
            n_vec++; if (!$onehot(target) || target === prev) begin
                n_err++; $display("[TB] FAIL hit_new_target: got %h expected one-hot other than %h", target, prev);
            end
            prev = target;
        end
    endtask

    task automatic test_wrong_press();
        logic [7:0] t;
        logic [7:0] pats [4];
        int got;
        t = target;
        n_vec++; if (!$onehot(t)) begin n_err++; $display("[TB] FAIL wrong_pre_target: got %h expected one-hot", t); end
        pats[0] = {t[6:0], t[7]};
        pats[1] = t | {t[6:0], t[7]};
        pats[2] = ~t;
        pats[3] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            model_score = after_loss(model_score);
            press(pats[i], model_score);
            got = exp_q.pop_front();
            n_vec++; if (score !== 5'(got)) begin n_err++; $display("[TB] FAIL wrong_score: got %0d expected %0d", score, got); end
            n_vec++; if (target !== t) begin n_err++; $display("[TB] FAIL wrong_target: got %h expected %h", target, t); end
        end
    endtask

    task automatic test_miss();
        logic [7:0] prev;
        int got;
        int cnt;
        start_game();
        step();
        for (int r = 0; r < 2; r++) begin
            model_score = after_hit(model_score);
            press(target, model_score);
            got = exp_q.pop_front();
            n_vec++; if (score !== 5'(got)) begin n_err++; $display("[TB] FAIL miss_pre_score: got %0d expected %0d", score, got); end
            step();
            step();
        end
        prev = target;
        n_vec++; if (!$onehot(prev)) begin n_err++; $display("[TB] FAIL miss_target: got %h expected one-hot", prev); end
        model_score = after_loss(model_score);
        exp_q.push_back(model_score);
        cnt = 0;
        while (target !== 8'h00 && cnt < 40) begin
            step();
            cnt++;
        end
        n_vec++; if (cnt != 20) begin n_err++; $display("[TB] FAIL miss_lit_cycles: got %0d expected 20", cnt); end
        got = exp_q.pop_front();
        n_vec++; if (score !== 5'(got)) begin n_err++; $display("[TB] FAIL miss_score: got %0d expected %0d", score, got); end
        step();
        n_vec++; if (target !== 8'h00) begin n_err++; $display("[TB] FAIL miss_gap: got %h expected 00", target); end
        step();
        n_vec++; if (!$onehot(target) || target === prev) begin
            n_err++; $display("[TB] FAIL miss_new_target: got %h expected one-hot other than %h", target, prev);
        end
    endtask

    task automatic test_hit_timeout();
        logic [7:0] t;
        int got;
        start_game();
        step();
        repeat (19) step();
        t = target;
        n_vec++; if (!$onehot(t)) begin n_err++; $display("[TB] FAIL hto_still_lit: got %h expected one-hot", t); end
        model_score = after_hit(model_score);
        press(t, model_score);
        got = exp_q.pop_front();
        n_vec++; if (score !== 5'(got)) begin n_err++; $display("[TB] FAIL hto_score: got %0d expected %0d", score, got); end
        n_vec++; if (target !== 8'h00) begin n_err++; $display("[TB] FAIL hto_clear: got %h expected 00", target); end
        step();
        step();
        n_vec++; if (!$onehot(target)) begin n_err++; $display("[TB] FAIL hto_next: got %h expected one-hot", target); end
    endtask

    task automatic test_game_timer();
        logic [4:0] exp_rem;
        start_game();
        for (int k = 1; k <= 45; k++) begin
            step();
            exp_rem = (k < 10) ? 5'd3 : (k < 20) ? 5'd2 : (k < 30) ? 5'd1 : 5'd0;
            n_vec++; if (remain !== exp_rem) begin n_err++; $display("[TB] FAIL timer_remain@%0d: got %0d expected %0d", k, remain, exp_rem); end
            n_vec++; if (tick !== (k == 30)) begin n_err++; $display("[TB] FAIL timer_tick@%0d: got %b expected %b", k, tick, (k == 30)); end
            if (k >= 30) begin
                n_vec++; if (target !== 8'h00) begin n_err++; $display("[TB] FAIL timer_target@%0d: got %h expected 00", k, target); end
            end
        end
        state_in = 3'b000;
        step();
        n_vec++; if (remain !== 5'd3) begin n_err++; $display("[TB] FAIL timer_idle_remain: got %0d expected 3", remain); end
        n_vec++; if (score !== 5'd0) begin n_err++; $display("[TB] FAIL timer_idle_score: got %0d expected 0", score); end
    endtask

    task automatic test_expiry_hit();
        logic [7:0] t;
        int got;
        start_game();
        repeat (29) step();
        t = target;
        n_vec++; if (!$onehot(t)) begin n_err++; $display("[TB] FAIL exp_target: got %h expected one-hot", t); end
        model_score = after_loss(model_score);
        model_score = after_hit(model_score);
        press(t, model_score);
        got = exp_q.pop_front();
        n_vec++; if (score !== 5'(got)) begin n_err++; $display("[TB] FAIL exp_score: got %0d expected %0d", score, got); end
        n_vec++; if (tick !== 1'b1) begin n_err++; $display("[TB] FAIL exp_tick: got %b expected 1", tick); end
        n_vec++; if (remain !== 5'd0) begin n_err++; $display("[TB] FAIL exp_remain: got %0d expected 0", remain); end
        n_vec++; if (target !== 8'h00) begin n_err++; $display("[TB] FAIL exp_clear: got %h expected 00", target); end
        step();
        n_vec++; if (tick !== 1'b0) begin n_err++; $display("[TB] FAIL exp_tick_once: got %b expected 0", tick); end
    endtask

    task automatic test_hold();
        logic [7:0] t;
        int got;
        int seen_tick;
        start_game();
        step();
        t = target;
        n_vec++; if (!$onehot(t)) begin n_err++; $display("[TB] FAIL hold_target: got %h expected one-hot", t); end
        state_in = 3'b010;
        model_score = after_hit(model_score);
        press(t, model_score);
        got = exp_q.pop_front();
        n_vec++; if (score !== 5'(got)) begin n_err++; $display("[TB] FAIL hold_hit_score: got %0d expected %0d", score, got); end
        n_vec++; if (target !== 8'h00) begin n_err++; $display("[TB] FAIL hold_clear: got %h expected 00", target); end
        seen_tick = 0;
        for (int k = 0; k < 35; k++) begin
            step();
            if (tick === 1'b1) seen_tick++;
        end
        n_vec++; if (target !== 8'h00) begin n_err++; $display("[TB] FAIL hold_target_frozen: got %h expected 00", target); end
        n_vec++; if (remain !== 5'd3) begin n_err++; $display("[TB] FAIL hold_remain: got %0d expected 3", remain); end
        n_vec++; if (score !== 5'(model_score)) begin n_err++; $display("[TB] FAIL hold_score: got %0d expected %0d", score, model_score); end
        n_vec++; if (seen_tick != 0) begin n_err++; $display("[TB] FAIL hold_tick: got %0d expected 0", seen_tick); end
        state_in = 3'b000;
        step();
        state_in = 3'b101;
        repeat (12) step();
        n_vec++; if (target !== 8'h00) begin n_err++; $display("[TB] FAIL undef_target: got %h expected 00", target); end
        n_vec++; if (remain !== 5'd3) begin n_err++; $display("[TB] FAIL undef_remain: got %0d expected 3", remain); end
        state_in = 3'b001;
        repeat (12) step();
        n_vec++; if (target !== 8'h00) begin n_err++; $display("[TB] FAIL hold_sticky: got %h expected 00", target); end
        state_in = 3'b000;
        step();
    endtask

    task automatic test_saturation();
        int got;
        int wait_cnt;
        int exp_s;
        s_state = 3'b001;
        step();
        for (int h = 0; h < 32; h++) begin
            wait_cnt = 0;
            while (s_target === 8'h00 && wait_cnt < 10) begin
                step();
                wait_cnt++;
            end
            n_vec++;
            if (s_target === 8'h00) begin
                n_err++; $display("[TB] FAIL sat_wait: got %h expected one-hot within 10 cycles", s_target);
                break;
            end
            exp_s = (h + 1 > 31) ? 31 : h + 1;
            s_push = s_target;
            exp_q.push_back(exp_s);
            step();
            s_push = 8'h00;
            got = exp_q.pop_front();
            n_vec++; if (s_score !== 5'(got)) begin n_err++; $display("[TB] FAIL sat_score@%0d: got %0d expected %0d", h, s_score, got); end
        end
        s_state = 3'b000;
        step();
    endtask

    task automatic test_reset();
        int got;
        start_game();
        step();
        for (int i = 0; i < 4; i++) begin
            model_score = after_hit(model_score);
            press(target, model_score);
            got = exp_q.pop_front();
            n_vec++; if (score !== 5'(got)) begin n_err++; $display("[TB] FAIL mrst_pre_score: got %0d expected %0d", score, got); end
            step();
            step();
        end
        n_vec++; if (!$onehot(target)) begin n_err++; $display("[TB] FAIL mrst_target: got %h expected one-hot", target); end
        rst = 1'b1;
        #1;
        n_vec++; if (target !== 8'h00) begin n_err++; $display("[TB] FAIL mrst_target_clr: got %h expected 00", target); end
        n_vec++; if (score !== 5'd0) begin n_err++; $display("[TB] FAIL mrst_score: got %0d expected 0", score); end
        n_vec++; if (remain !== 5'd3) begin n_err++; $display("[TB] FAIL mrst_remain: got %0d expected 3", remain); end
        n_vec++; if (tick !== 1'b0) begin n_err++; $display("[TB] FAIL mrst_tick: got %b expected 0", tick); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        n_vec++; if (target !== 8'h00) begin n_err++; $display("[TB] FAIL mrst_arm: got %h expected 00", target); end
        step();
        n_vec++; if (!$onehot(target)) begin n_err++; $display("[TB] FAIL mrst_restart: got %h expected one-hot", target); end
    endtask

    initial begin
        test_reset_values();
        test_hit();
        test_wrong_press();
        test_miss();
        test_hit_timeout();
        test_game_timer();
        test_expiry_hit();
        test_hold();
        test_saturation();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
